demux_chan_counter: RTL and testbench

DEMUX_CHAN_COUNTER -- requirements
Module: demux_chan_counter

---
 rtl/demux_chan_counter.sv | 100 ++++++++++
 tb/tb_demux_chan_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_chan_counter.sv
// Four saturating event counters fed by a one-hot demux strobe, with read-and-clear access.
// Optional macro DEMUX_CNT_EDGE_EN counts rising edges of each strobe instead of high cycles.
module demux_chan_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ch_in,
    input  logic             clr,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [3:0]       overflow,
    output logic             err_multi
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       ev;
    logic             ev_one_hot;
    logic             ev_multi;
    logic [CNT_W-1:0] cnt_all [4];

`ifdef DEMUX_CNT_EDGE_EN
    logic [3:0] ch_prev_reg;

    // History follows ch_in through clr so a held strobe is not recounted after a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_prev_reg <= 4'b0000;
        end else begin
            ch_prev_reg <= ch_in;
        end
    end

    assign ev = ch_in & ~ch_prev_reg;
`else
    assign ev = ch_in;
`endif

    always_comb begin
        ev_one_hot = $onehot(ev);
        ev_multi   = (ev != 4'b0000) && !ev_one_hot;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic             inc;
            logic             rd_hit;
            logic [CNT_W-1:0] cnt_reg;
            logic             ovf_reg;

            assign inc    = ev_one_hot && ev[gi];
            assign rd_hit = rd_req && (rd_sel == 2'(gi));

            // A read that coincides with an event restarts the count at 1 so the event survives.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (rd_hit) begin
                    cnt_reg <= inc ? CNT_ONE : '0;
                    ovf_reg <= 1'b0;
                end else if (inc) begin
                    if (cnt_reg == CNT_MAX) begin
                        ovf_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            end

            assign cnt_all[gi]  = cnt_reg;
            assign overflow[gi] = ovf_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            err_multi <= 1'b0;
        end else if (clr) begin
            rd_valid  <= 1'b0;
            err_multi <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= cnt_all[rd_sel];
            end
            if (ev_multi) begin
                err_multi <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_chan_counter.sv
// Self-checking bench for demux_chan_counter: directed scenarios plus random traffic
// compared every cycle against an array-based model of the counting rules.
module tb_demux_chan_counter;

    localparam int CNT_W = 8;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       ch_in = 4'b0000;
    logic             clr = 1'b0;
    logic             rd_req = 1'b0;
    logic [1:0]       rd_sel = 2'd0;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic [3:0]       overflow;
    logic             err_multi;

    demux_chan_counter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_in     (ch_in),
        .clr       (clr),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .overflow  (overflow),
        .err_multi (err_multi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference state: plain integers per channel.
    int   m_cnt [4];
    bit   m_ovf [4];
    bit   m_err;
    bit   m_valid;
    int   m_data;
    logic [3:0] m_prev;

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_data  = 0;
        m_prev  = 4'b0000;
    end

    function automatic logic [3:0] m_ovf_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic model_update(input logic [3:0] ch, input bit c, input bit r,
                                input logic [1:0] s, input bit rs);
        logic [3:0] ev;
        int         nset;
        bit         hit;
        if (rs) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end
            m_err   = 1'b0;
            m_valid = 1'b0;
            m_data  = 0;
            m_prev  = 4'b0000;
            return;
        end
`ifdef DEMUX_CNT_EDGE_EN
        ev = ch & ~m_prev;
`else
        ev = ch;
`endif
        m_prev = ch;
        if (c) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end
            m_err   = 1'b0;
            m_valid = 1'b0;
            return;
        end
        m_valid = r;
        if (r) m_data = m_cnt[s];
        nset = $countones(ev);
        if (nset > 1) m_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hit = (nset == 1) && ev[i];
            if (r && (int'(s) == i)) begin
                m_cnt[i] = hit ? 1 : 0;
                m_ovf[i] = 1'b0;
            end else if (hit) begin
                if (m_cnt[i] == MAX) m_ovf[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rd_valid", 32'(rd_valid), 32'(m_valid));
            check("cyc_rd_data", 32'(rd_data), 32'(m_data));
            check("cyc_overflow", 32'(overflow), 32'(m_ovf_vec()));
            check("cyc_err_multi", 32'(err_multi), 32'(m_err));
            if (rd_valid) $display("read -> %0d (ovf=%b err=%b)", rd_data, overflow, err_multi);
        end
    end

    task automatic step(input logic [3:0] ch, input bit c, input bit r,
                        input logic [1:0] s, input bit rs);
        ch_in  = ch;
        clr    = c;
        rd_req = r;
        rd_sel = s;
        rst    = rs;
        @(posedge clk);
        model_update(ch, c, r, s, rs);
        #1;
    endtask

    task automatic idle(input logic [3:0] ch);
        step(ch, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] s);
        step(4'b0000, 1'b0, 1'b1, s, 1'b0);
    endtask

    // Strobe then gap: one event in both level and edge mode.
    task automatic pulse(input logic [3:0] ch, input int n);
        for (int k = 0; k < n; k++) begin
            idle(ch);
            idle(4'b0000);
        end
    endtask

    initial begin
        int         r;
        logic [3:0] ch;
        bit         c, q, rs;

        step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
        chk_en = 1'b1;
        step(4'b1111, 1'b1, 1'b1, 2'd3, 1'b1);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_err", 32'(err_multi), 32'd0);

        // Five high cycles on channel 1, then read-and-clear twice.
        step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        pulse(4'b0010, 5);
        rd(2'd1);
        check("ch1_valid", 32'(rd_valid), 32'd1);
        check("ch1_count5", 32'(rd_data), 32'd5);
        rd(2'd1);
        check("ch1_reread0", 32'(rd_data), 32'd0);
        idle(4'b0000);
        check("valid_drops", 32'(rd_valid), 32'd0);

        // 260 events saturate channel 3.
        pulse(4'b1000, 260);
        check("sat_overflow", 32'(overflow), 32'h8);
        rd(2'd3);
        check("sat_data", 32'(rd_data), 32'd255);
        check("sat_ovf_clear", 32'(overflow), 32'h0);

        // Non-one-hot strobe: sticky error, counters untouched, clr releases it.
        idle(4'b0110);
        check("multi_err", 32'(err_multi), 32'd1);
        idle(4'b0000);
        rd(2'd2);
        check("multi_ch2_unchanged", 32'(rd_data), 32'd0);
        idle(4'b0000);
        check("multi_err_sticky", 32'(err_multi), 32'd1);
        step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
        check("clr_err", 32'(err_multi), 32'd0);

        // Read-and-clear colliding with an increment on the same channel.
        pulse(4'b0001, 7);
        step(4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
        check("collide_data7", 32'(rd_data), 32'd7);
        rd(2'd0);
        check("collide_left1", 32'(rd_data), 32'd1);

        // clr drops a coincident read.
        pulse(4'b0100, 3);
        step(4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
        check("clr_drops_read", 32'(rd_valid), 32'd0);
        rd(2'd2);
        check("clr_zeroes", 32'(rd_data), 32'd0);

        // rst mid-count with error set and a read in flight.
        pulse(4'b0001, 3);
        rd(2'd0);
        check("pre_rst_read", 32'(rd_data), 32'd3);
        pulse(4'b0001, 2);
        idle(4'b0011);
        step(4'b0001, 1'b0, 1'b1, 2'd0, 1'b1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_err", 32'(err_multi), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rd(2'd0);
        check("rst_cleared_cnt", 32'(rd_data), 32'd0);

        // Held strobe: counts edges with the macro, high cycles without.
        for (int k = 0; k < 4; k++) idle(4'b0100);
        idle(4'b0000);
        idle(4'b0100);
        idle(4'b0100);
        rd(2'd2);
`ifdef DEMUX_CNT_EDGE_EN
        check("held_strobe", 32'(rd_data), 32'd2);
`else
        check("held_strobe", 32'(rd_data), 32'd6);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35) ch = 4'b0000;
            else if (r < 90) ch = 4'b0001 << $urandom_range(0, 3);
            else ch = 4'($urandom);
            c  = ($urandom_range(0, 199) == 0);
            rs = ($urandom_range(0, 399) == 0);
            q  = ($urandom_range(0, 99) < 20);
            step(ch, c, q, 2'($urandom_range(0, 3)), rs);
        end

        idle(4'b0000);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
